// File: rtl/multibit_sync_rx_if.sv
// Bus between the skewed crossing source and the multi-bit CDC receiver.
// master = source/consumer side, slave = receiver.
interface multibit_sync_rx_if #(
    parameter int NB_DATA = 8,
    parameter int NB_CNT  = 16
);
    logic [NB_DATA-1:0] data;
    logic               req_tgl;
    logic               ack_tgl;
    logic [NB_DATA-1:0] rx_data;
    logic               valid;
    logic               ready;
    logic               busy;
    logic               err;
    logic [NB_CNT-1:0]  xfer_cnt;

    modport master (
        output data, req_tgl, ready,
        input  ack_tgl, rx_data, valid, busy, err, xfer_cnt
    );

    modport slave (
        input  data, req_tgl, ready,
        output ack_tgl, rx_data, valid, busy, err, xfer_cnt
    );
endinterface

// File: rtl/multibit_sync_rx.sv
// Destination side of a toggle req/ack multi-bit CDC: synchronizes the request,
// captures the bus once settled, hands it out on valid/ready and returns an ack toggle.
//
// state    | meaning
// ST_IDLE  | no word held, waiting for a synchronized request edge
// ST_VALID | word captured and offered downstream, waiting for ready
module multibit_sync_rx #(
    parameter int NB_DATA = 8,
    parameter int NB_SYNC = 2,
    parameter int NB_CNT  = 16
) (
    input logic                clk,
    input logic                rst_n,
    multibit_sync_rx_if.slave  bus
);
    typedef enum logic {ST_IDLE, ST_VALID} state_t;

    state_t             state_q, state_d;
    logic [NB_SYNC-1:0] sync_q;
    logic               req_d;
    logic               req_pulse;
    logic [NB_DATA-1:0] data_q;
    logic               ack_q;
    logic               err_q;
    logic [NB_CNT-1:0]  cnt_q;
    logic               capture;
    logic               handshake;
    logic               violation;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            req_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[NB_SYNC-2:0], bus.req_tgl};
            req_d  <= sync_q[NB_SYNC-1];
        end
    end

    assign req_pulse = sync_q[NB_SYNC-1] ^ req_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // A request edge while a word is still held is flagged and dropped.
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        handshake = 1'b0;
        violation = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_pulse) begin
                    capture = 1'b1;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                violation = req_pulse;
                if (bus.ready) begin
                    handshake = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (capture) data_q <= bus.data;
            if (handshake) begin
                ack_q <= ~ack_q;
                cnt_q <= cnt_q + NB_CNT'(1);
            end
            if (violation) err_q <= 1'b1;
        end
    end

    assign bus.rx_data  = data_q;
    assign bus.valid    = (state_q == ST_VALID);
    assign bus.ack_tgl  = ack_q;
    assign bus.busy     = req_pulse | (state_q == ST_VALID);
    assign bus.err      = err_q;
    assign bus.xfer_cnt = cnt_q;
endmodule

// File: tb/tb_multibit_sync_rx.sv
// Self-checking bench for multibit_sync_rx: vector table, hand-written corner
// sequences and a randomized skewed-bus run checked against a word queue model.
`timescale 1ns/1ps
module tb_multibit_sync_rx;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   exp_cnt;

    multibit_sync_rx_if #(.NB_DATA(8), .NB_CNT(16)) bus ();
    multibit_sync_rx_if #(.NB_DATA(8), .NB_CNT(3))  bus2 ();

    multibit_sync_rx #(.NB_DATA(8), .NB_SYNC(2), .NB_CNT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Narrow-counter copy sees the same stimulus to exercise counter wrap.
    multibit_sync_rx #(.NB_DATA(8), .NB_SYNC(2), .NB_CNT(3)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    assign bus2.data    = bus.data;
    assign bus2.req_tgl = bus.req_tgl;
    assign bus2.ready   = bus.ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [7:0]  data;
        logic        ready;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic        exp_ack;
        logic        exp_busy;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] w;
        logic       prev_ack;
        bit         done;

        checks   = 0;
        failures = 0;
        exp_cnt  = 0;
        rst_n       = 1'b0;
        bus.data    = '0;
        bus.req_tgl = 1'b0;
        bus.ready   = 1'b0;

        // single transfer, zero-wait: capture after edge 2, ack after edge 3
        vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0};
        vecs[2] = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 16'd0};
        vecs[3] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 16'd1};
        vecs[4] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 16'd1};

        // reset then idle
        repeat (3) tick();
        chk("rst_valid", bus.valid, 0);
        chk("rst_data", bus.rx_data, 0);
        chk("rst_ack", bus.ack_tgl, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_cnt", bus.xfer_cnt, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_valid", bus.valid, 0);
        end
        chk("idle_cnt", bus.xfer_cnt, 0);

        for (int i = 0; i < 5; i++) begin
            bus.req_tgl = vecs[i].req;
            bus.data    = vecs[i].data;
            bus.ready   = vecs[i].ready;
            tick();
            chk($sformatf("vec%0d_valid", i), bus.valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d_data", i), bus.rx_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_ack", i), bus.ack_tgl, vecs[i].exp_ack);
            chk($sformatf("vec%0d_busy", i), bus.busy, vecs[i].exp_busy);
            chk($sformatf("vec%0d_cnt", i), bus.xfer_cnt, vecs[i].exp_cnt);
        end
        exp_cnt = 1;

        // backpressure: hold for 10 cycles, ack only after ready edge
        bus.ready   = 1'b0;
        bus.data    = 8'h3C;
        bus.req_tgl = ~bus.req_tgl;
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", bus.valid, 1);
            chk("bp_data", bus.rx_data, 8'h3C);
            chk("bp_ack", bus.ack_tgl, 1);
            if (i < 9) tick();
        end
        bus.ready = 1'b1;
        tick();
        exp_cnt++;
        chk("bp_valid_fall", bus.valid, 0);
        chk("bp_ack_tgl", bus.ack_tgl, 0);
        chk("bp_cnt", bus.xfer_cnt, exp_cnt);

        // randomized words over a per-bit skewed bus, random consumer stall
        for (int k = 0; k < 200; k++) begin
            w        = 8'($urandom);
            prev_ack = bus.ack_tgl;
            bus.req_tgl = ~bus.req_tgl;
            for (int b = 0; b < 8; b++) begin
                #($urandom_range(0, 1));
                bus.data[b] = w[b];
            end
            done = 1'b0;
            for (int c = 0; c < 100 && !done; c++) begin
                bus.ready = 1'($urandom_range(0, 1));
                tick();
                if (bus.valid) chk("rnd_data", bus.rx_data, w);
                if (bus.ack_tgl != prev_ack) done = 1'b1;
            end
            if (!done) begin
                checks++;
                failures++;
                $display("FAIL rnd_timeout: word %0d got no ack, expected one within 100 cycles", k);
            end
            exp_cnt++;
            chk("rnd_cnt", bus.xfer_cnt, exp_cnt);
        end
        chk("rnd_err", bus.err, 0);

        // protocol violation: second toggle before ack
        bus.ready   = 1'b0;
        bus.data    = 8'h11;
        bus.req_tgl = ~bus.req_tgl;
        repeat (3) tick();
        chk("viol_first_valid", bus.valid, 1);
        bus.data    = 8'h22;
        bus.req_tgl = ~bus.req_tgl;
        repeat (4) tick();
        chk("viol_err", bus.err, 1);
        chk("viol_data", bus.rx_data, 8'h11);
        chk("viol_valid", bus.valid, 1);
        bus.ready = 1'b1;
        tick();
        exp_cnt++;
        chk("viol_cnt", bus.xfer_cnt, exp_cnt);
        repeat (4) tick();
        chk("viol_dropped", bus.valid, 0);
        chk("viol_cnt_hold", bus.xfer_cnt, exp_cnt);
        chk("viol_err_sticky", bus.err, 1);
        chk("wrap_cnt", bus2.xfer_cnt, exp_cnt % 8);

        // async reset while a word is held
        bus.ready   = 1'b0;
        bus.data    = 8'h5A;
        bus.req_tgl = ~bus.req_tgl;
        repeat (3) tick();
        chk("ar_valid_pre", bus.valid, 1);
        #2;
        rst_n       = 1'b0;
        bus.req_tgl = 1'b0;
        #1;
        chk("ar_valid", bus.valid, 0);
        chk("ar_ack", bus.ack_tgl, 0);
        chk("ar_cnt", bus.xfer_cnt, 0);
        chk("ar_err", bus.err, 0);
        chk("ar_data", bus.rx_data, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_wrap_cnt", bus2.xfer_cnt, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post_rst_valid", bus.valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multibit_sync_rx.md
# multibit_sync_rx

Destination-side receiver for a multi-bit clock-domain crossing that uses a toggle request/acknowledge handshake. It sits directly downstream of the per-bit random-skew model of the crossing bus. It synchronizes the source's request toggle, captures the skewed data bus once it is guaranteed stable, and presents the word on a valid/ready interface. It then returns an acknowledge toggle to the source domain and counts completed transfers.

## Interface
- NB_DATA, 8, width of crossing data bus and o_data
- NB_SYNC, 2, synchronizer depth for i_req_tgl (legal ≥ 2)
- NB_CNT, 16, width of transfer counter
- i_clk  input  1  destination clock, all logic on rising edge
- i_rst_n  input  1  asynchronous active-low reset (one clock; polarity and asynchronous assertion fixed)
- i_data  input  NB_DATA  skewed bus from source domain; held stable by the source from its request toggle until it sees the ack toggle
- i_req_tgl  input  1  source request toggle (asynchronous to i_clk); each level change announces one new word
- o_ack_tgl  output  1  acknowledge toggle back to source; changes level once per consumed word
- o_data  output  NB_DATA  captured word, stable while o_valid=1
- o_valid  output  1  captured word available
- i_ready  input  1  downstream consumer ready
- o_busy  output  1  high from request detection until ack toggle issued
- o_err  output  1  sticky protocol error flag
- o_xfer_cnt  output  NB_CNT  completed transfers, modulo 2^NB_CNT

## Operation
- Sync chain s[0..NB_SYNC-1]: s[0] samples i_req_tgl; s[k] samples s[k-1]. Edge register req_d samples s[NB_SYNC-1] every cycle.
- req_pulse = s[NB_SYNC-1] XOR req_d (combinational, one cycle wide per toggle).
- i_data is never passed through the sync chain. It is sampled only in the capture cycle. Correctness requires upstream bit skew plus setup time to be less than NB_SYNC-1 i_clk periods.
- FSM, two states:
  - IDLE: o_valid=0. On req_pulse: o_data <= i_data, o_valid <= 1, go to VALID.
  - VALID: o_valid=1, o_data held. On o_valid & i_ready: o_valid <= 0, o_ack_tgl <= ~o_ack_tgl, o_xfer_cnt <= o_xfer_cnt+1, go to IDLE.
- o_busy = req_pulse | (state==VALID).
- A req_pulse while in VALID is a protocol violation (source toggled again before ack):
  - o_err <= 1.
  - The pulse is dropped and o_data is not overwritten.
  - If a handshake occurs on the same edge, the handshake still completes normally.
- o_err clears only on reset.
- o_xfer_cnt wraps from 2^NB_CNT-1 to 0 without a flag.

## Timing
- Reset (async assert, sync release by the environment) drives the following values:
  - s[*]=0, req_d=0, state=IDLE.
  - o_data=0, o_valid=0, o_ack_tgl=0.
  - o_busy=0, o_err=0, o_xfer_cnt=0.
- Request latency: i_req_tgl changes before edge 0, then s[NB_SYNC-1] updates at edge NB_SYNC-1.
  - req_pulse is high in the cycle after that edge.
  - Capture happens at edge NB_SYNC, so o_valid is first high after edge NB_SYNC (edge 2 for the default).
- Handshake: transfer occurs on the edge where o_valid=1 and i_ready=1.
  - o_valid falls and o_ack_tgl toggles after that same edge.
  - Zero-wait: if i_ready is held at 1, o_valid is high for exactly one cycle.
- o_valid, once high, stays high and o_data stays constant until the handshake (no retraction).
- Back-to-back words: the next req_pulse may arrive no earlier than the cycle after the ack edge. It is then accepted normally.
- Reset mid-transfer: all state is lost and o_ack_tgl returns to 0. The source domain must be reset in the same reset event.

## Test plan
- Reset then idle: hold i_rst_n=0 for 3 cycles, release; all outputs 0; i_req_tgl static for 20 cycles -> o_valid stays 0, o_xfer_cnt=0.
- Single transfer, NB_SYNC=2: i_data=8'hA5 with i_req_tgl 0->1 before edge 0, i_ready=1 -> o_valid=1 after edge 2 with o_data=8'hA5; o_ack_tgl=1 and o_xfer_cnt=1 after edge 3.
- Backpressure: i_data=8'h3C, i_ready=0 for 10 cycles then 1 -> o_valid and o_data=8'h3C held all 10 cycles; ack toggles only after the ready edge.
- Skewed bus: 200 random words through the skew stage (skew below one i_clk period), source waits for ack each time -> every o_data equals the sent word, o_xfer_cnt=200, o_err=0.
- Protocol violation: toggle i_req_tgl twice (words 8'h11 then 8'h22) with i_ready=0 -> o_err=1, o_data stays 8'h11; after ready, o_xfer_cnt=1.
- Async reset during VALID: assert i_rst_n=0 between edges -> o_valid, o_ack_tgl, o_xfer_cnt go to 0 immediately, before the next edge.
